// File: rtl/vga_sync_decoder_pkg.sv
// Shared 640x480 timing constants, FSM state type and counter helpers for the
// VGA sync decoder; the timing generator uses the same constants.
package vga_sync_decoder_pkg;

  localparam int unsigned CNT_W = 11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam int unsigned DEF_H_TOTAL     = 800;
  localparam int unsigned DEF_H_START     = 144;
  localparam int unsigned DEF_H_ACTIVE    = 640;
  localparam int unsigned DEF_V_TOTAL     = 525;
  localparam int unsigned DEF_V_START     = 35;
  localparam int unsigned DEF_V_ACTIVE    = 480;
  localparam logic        DEF_HS_POL      = 1'b0;
  localparam logic        DEF_VS_POL      = 1'b0;
  localparam int unsigned DEF_LOCK_FRAMES = 2;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 11'd1;
  endfunction

endpackage

// File: rtl/vga_sync_decoder_sync_edge_meas.sv
// Sync sampler with leading-edge detect and a saturating position counter that
// clears on the edge and otherwise advances on inc.
module sync_edge_meas
  import vga_sync_decoder_pkg::*;
#(
  parameter logic POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_in,
  input  logic             inc,
  output logic             lead,
  output logic [CNT_W-1:0] pos
);

  logic sync_q;
  logic sync_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= ~POL;
      sync_prev <= ~POL;
      pos       <= '0;
    end else if (en) begin
      sync_q    <= sync_in;
      sync_prev <= sync_q;
      if (lead)
        pos <= '0;
      else if (inc)
        pos <= sat_inc(pos);
    end
  end

  assign lead = (sync_q == POL) && (sync_prev != POL);

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing monitor: recovers active-area coordinates and data
// enable from hs/vs/RGB, measures line/frame length and tracks timing lock.
module vga_sync_decoder
  import vga_sync_decoder_pkg::*;
#(
  parameter int unsigned H_TOTAL     = DEF_H_TOTAL,
  parameter int unsigned H_START     = DEF_H_START,
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned V_TOTAL     = DEF_V_TOTAL,
  parameter int unsigned V_START     = DEF_V_START,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter logic        HS_POL      = DEF_HS_POL,
  parameter logic        VS_POL      = DEF_VS_POL,
  parameter int unsigned LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pixel_en,
  input  logic              hs,
  input  logic              vs,
  input  logic [2:0]        red,
  input  logic [2:0]        green,
  input  logic [1:0]        blue,
  output logic [CNT_W-1:0]  hcount,
  output logic [CNT_W-1:0]  vcount,
  output logic              de,
  output logic [7:0]        pix,
  output logic              locked,
  output logic [CNT_W-1:0]  line_len,
  output logic [CNT_W-1:0]  frame_lines,
  output logic              err
);

  localparam logic [CNT_W-1:0] H_TOTAL_C = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] H_END_C   = CNT_W'(H_START + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_TOTAL_C = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] V_END_C   = CNT_W'(V_START + V_ACTIVE);
  localparam logic [7:0]       LOCK_C    = 8'(LOCK_FRAMES);

  logic             hs_lead;
  logic             vs_lead;
  logic [CNT_W-1:0] hpos;
  logic [CNT_W-1:0] vpos;

  sync_edge_meas #(.POL(HS_POL)) u_hmeas (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (pixel_en),
    .sync_in (hs),
    .inc     (1'b1),
    .lead    (hs_lead),
    .pos     (hpos)
  );

  // vpos counts hs edges; its own vs edge clear takes priority on a shared edge
  sync_edge_meas #(.POL(VS_POL)) u_vmeas (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (pixel_en),
    .sync_in (vs),
    .inc     (hs_lead),
    .lead    (vs_lead),
    .pos     (vpos)
  );

  logic [CNT_W-1:0] line_meas;
  logic [CNT_W-1:0] frame_meas;
  logic             hsat;
  logic             line_bad;
  logic             frame_good;
  logic             frame_ok;
  logic             active;

  assign line_meas  = sat_inc(hpos);
  assign frame_meas = sat_inc(vpos);
  assign hsat       = (hpos == CNT_MAX) && !hs_lead;
  assign line_bad   = (hs_lead && (line_meas != H_TOTAL_C)) || hsat;
  // The line closed by a coincident hs edge belongs to the frame being judged
  assign frame_good = frame_ok && !line_bad && (frame_meas == V_TOTAL_C);
  assign active     = (hpos >= H_START_C) && (hpos < H_END_C) &&
                      (vpos >= V_START_C) && (vpos < V_END_C);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] good_cnt;
  logic [7:0] good_nxt;
  logic       err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    err_nxt   = 1'b0;
    if (pixel_en) begin
      unique case (state)
        ST_SEARCH: begin
          if (vs_lead && !hsat) begin
            state_nxt = ST_VERIFY;
            good_nxt  = '0;
          end
        end
        ST_VERIFY: begin
          if (hsat) begin
            state_nxt = ST_SEARCH;
          end else if (vs_lead) begin
            if (!frame_good)
              good_nxt = '0;
            else if ((good_cnt + 8'd1) >= LOCK_C)
              state_nxt = ST_LOCKED;
            else
              good_nxt = good_cnt + 8'd1;
          end
        end
        ST_LOCKED: begin
          if (line_bad || (vs_lead && !frame_good)) begin
            state_nxt = ST_SEARCH;
            err_nxt   = 1'b1;
          end
        end
        default: state_nxt = ST_SEARCH;
      endcase
    end
  end

  // rgb_q2 delays the sample one tick so it lines up with hpos/vpos
  logic [7:0] rgb_q;
  logic [7:0] rgb_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q       <= '0;
      rgb_q2      <= '0;
      frame_ok    <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      de          <= 1'b0;
      pix         <= '0;
      locked      <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
      err         <= 1'b0;
    end else begin
      err <= err_nxt;
      if (pixel_en) begin
        rgb_q  <= {red, green, blue};
        rgb_q2 <= rgb_q;
        if (hs_lead)
          line_len <= line_meas;
        if (vs_lead)
          frame_lines <= frame_meas;
        if (vs_lead)
          frame_ok <= 1'b1;
        else if (line_bad)
          frame_ok <= 1'b0;
        locked <= (state_nxt == ST_LOCKED);
        de     <= active && (state_nxt == ST_LOCKED);
        hcount <= active ? (hpos - H_START_C) : '0;
        vcount <= active ? (vpos - V_START_C) : '0;
        pix    <= rgb_q2;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a reduced 40x16 timing: a generator model drives
// hs/vs/RGB and queues the expected output of each pixel two ticks ahead.
module tb_vga_sync_decoder;

  localparam int H_TOTAL  = 40;
  localparam int H_START  = 6;
  localparam int H_ACTIVE = 30;
  localparam int V_TOTAL  = 16;
  localparam int V_START  = 3;
  localparam int V_ACTIVE = 12;
  localparam int H_SYNC   = 4;
  localparam int V_SYNC   = 2;
  localparam int LOCK     = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pixel_en;
  logic        hs;
  logic        vs;
  logic [2:0]  red;
  logic [2:0]  green;
  logic [1:0]  blue;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        de;
  logic [7:0]  pix;
  logic        locked;
  logic [10:0] line_len;
  logic [10:0] frame_lines;
  logic        err;

  vga_sync_decoder #(
    .H_TOTAL     (H_TOTAL),
    .H_START     (H_START),
    .H_ACTIVE    (H_ACTIVE),
    .V_TOTAL     (V_TOTAL),
    .V_START     (V_START),
    .V_ACTIVE    (V_ACTIVE),
    .HS_POL      (1'b0),
    .VS_POL      (1'b0),
    .LOCK_FRAMES (LOCK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_en    (pixel_en),
    .hs          (hs),
    .vs          (vs),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .hcount      (hcount),
    .vcount      (vcount),
    .de          (de),
    .pix         (pix),
    .locked      (locked),
    .line_len    (line_len),
    .frame_lines (frame_lines),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [10:0] hc;
    logic [10:0] vc;
    logic        de;
    logic [7:0]  pix;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;

  int hc = 0;
  int vc = 0;
  int short_vc = -1;
  int vs_seen = 0;
  bit exp_locked = 0;
  bit aligned = 0;

  always @(negedge clk) if (err === 1'b1) err_cnt++;

  // Scoreboard: output seen after tick n belongs to the pixel sampled at tick n-2
  always @(posedge clk) begin
    if (pixel_en && rst_n) begin
      #1;
      if (sb.size() >= 3) begin
        mon_e = sb.pop_front();
        tests++;
        if (mon_e.chk) begin
          if ({hcount, vcount, de, pix} !== {mon_e.hc, mon_e.vc, mon_e.de, mon_e.pix}) begin
            fails++;
            $display("FAIL sb_pixel: hcount=%0d vcount=%0d de=%0b pix=%02h, expected %0d %0d %0b %02h",
                     hcount, vcount, de, pix, mon_e.hc, mon_e.vc, mon_e.de, mon_e.pix);
          end
        end else if (de !== mon_e.de) begin
          fails++;
          $display("FAIL sb_de: de=%0b, expected %0b", de, mon_e.de);
        end
      end
    end
  end

  function automatic logic [7:0] gen_rgb(input int x, input int y);
    if (x < H_START || x >= H_START + H_ACTIVE || y < V_START || y >= V_START + V_ACTIVE)
      return 8'h00;
    if (x == H_START + 20 && y == V_START + 8)
      return 8'hFF;
    return 8'(x * 7 + y * 13);
  endfunction

  task automatic gen1();
    sb_t e;
    bit  act;
    logic [7:0] rgb;
    if (hc == 0 && vc == 0) begin
      vs_seen++;
      aligned = 1;
      if (vs_seen == LOCK + 1) exp_locked = 1;
    end
    act   = (hc >= H_START) && (hc < H_START + H_ACTIVE) &&
            (vc >= V_START) && (vc < V_START + V_ACTIVE);
    rgb   = gen_rgb(hc, vc);
    e.chk = aligned;
    e.hc  = act ? 11'(hc - H_START) : 11'd0;
    e.vc  = act ? 11'(vc - V_START) : 11'd0;
    e.de  = act && exp_locked;
    e.pix = rgb;
    @(negedge clk);
    sb.push_back(e);
    pixel_en = 1'b1;
    hs = (hc < H_SYNC) ? 1'b0 : 1'b1;
    vs = (vc < V_SYNC) ? 1'b0 : 1'b1;
    {red, green, blue} = rgb;
    @(negedge clk);
    pixel_en = 1'b0;
    if (hc == H_TOTAL - 1 || (vc == short_vc && hc == H_TOTAL - 2)) begin
      if (vc == short_vc) begin
        short_vc   = -1;
        exp_locked = 0;
        vs_seen    = 0;
      end
      hc = 0;
      vc = (vc + 1) % V_TOTAL;
    end else begin
      hc++;
    end
  endtask

  task automatic run_to(input int th, input int tv);
    int guard = 0;
    while (!(hc == th && vc == tv)) begin
      if (guard >= 2000) begin
        tests++;
        fails++;
        $display("FAIL run_to_timeout: at (%0d,%0d), required (%0d,%0d)", hc, vc, th, tv);
        return;
      end
      gen1();
      guard++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({hcount, vcount, de, pix, locked, line_len, frame_lines, err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: hcount=%0d vcount=%0d de=%0b pix=%02h locked=%0b line_len=%0d frame_lines=%0d err=%0b, required all 0",
               hcount, vcount, de, pix, locked, line_len, frame_lines, err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    gen1();
    run_to(0, 0); gen1();
    run_to(0, 0); gen1();
    tests++;
    if (locked !== 1'b0) begin
      fails++;
      $display("FAIL lock_early: locked=%0b, required 0", locked);
    end
    gen1();
    tests++;
    if (locked !== 1'b1) begin
      fails++;
      $display("FAIL lock_time: locked=%0b, required 1", locked);
    end
    tests++;
    if (line_len !== 11'(H_TOTAL)) begin
      fails++;
      $display("FAIL lock_line_len: line_len=%0d, required %0d", line_len, H_TOTAL);
    end
    tests++;
    if (frame_lines !== 11'(V_TOTAL)) begin
      fails++;
      $display("FAIL lock_frame_lines: frame_lines=%0d, required %0d", frame_lines, V_TOTAL);
    end
  endtask

  task automatic test_ball();
    run_to(H_START + 20, V_START + 8);
    gen1();
    gen1();
    tests++;
    if (hcount !== 11'd19 || pix === 8'hFF) begin
      fails++;
      $display("FAIL ball_latency: hcount=%0d pix=%02h one tick after sample, required hcount 19 and pix not ff", hcount, pix);
    end
    gen1();
    tests++;
    if ({pix, hcount, vcount, de} !== {8'hFF, 11'd20, 11'd8, 1'b1}) begin
      fails++;
      $display("FAIL ball_pixel: pix=%02h hcount=%0d vcount=%0d de=%0b, required ff 20 8 1", pix, hcount, vcount, de);
    end
  endtask

  task automatic test_same_edge();
    logic [7:0] exp_pix;
    run_to(0, 0);
    repeat (3) gen1();
    tests++;
    if (frame_lines !== 11'(V_TOTAL) || line_len !== 11'(H_TOTAL)) begin
      fails++;
      $display("FAIL same_edge_meas: frame_lines=%0d line_len=%0d, required %0d %0d", frame_lines, line_len, V_TOTAL, H_TOTAL);
    end
    exp_pix = gen_rgb(H_START, V_START);
    run_to(H_START, V_START);
    repeat (3) gen1();
    tests++;
    if ({hcount, vcount, de, pix} !== {11'd0, 11'd0, 1'b1, exp_pix}) begin
      fails++;
      $display("FAIL same_edge_origin: hcount=%0d vcount=%0d de=%0b pix=%02h, required 0 0 1 %02h", hcount, vcount, de, pix, exp_pix);
    end
    tests++;
    if (err_cnt !== 0) begin
      fails++;
      $display("FAIL nominal_err: err pulses=%0d, required 0", err_cnt);
    end
  endtask

  task automatic test_short_line();
    int err0;
    err0 = err_cnt;
    short_vc = 5;
    run_to(0, 6);
    repeat (3) gen1();
    tests++;
    if (err_cnt !== err0 + 1) begin
      fails++;
      $display("FAIL short_err: err pulses=%0d, required %0d", err_cnt - err0, 1);
    end
    tests++;
    if (locked !== 1'b0 || de !== 1'b0) begin
      fails++;
      $display("FAIL short_unlock: locked=%0b de=%0b, required 0 0", locked, de);
    end
    run_to(0, 0); gen1();
    run_to(0, 0); gen1();
    run_to(0, 0); gen1();
    tests++;
    if (locked !== 1'b0) begin
      fails++;
      $display("FAIL short_relock_early: locked=%0b, required 0", locked);
    end
    gen1();
    tests++;
    if (locked !== 1'b1 || err_cnt !== err0 + 1) begin
      fails++;
      $display("FAIL short_relock: locked=%0b err pulses=%0d, required 1 1", locked, err_cnt - err0);
    end
  endtask

  task automatic test_stuck_hs();
    int  err0;
    sb_t e;
    run_to(0, 5);
    err0 = err_cnt;
    exp_locked = 0;
    vs_seen = 0;
    aligned = 0;
    e.chk = 0; e.hc = '0; e.vc = '0; e.de = 1'b0; e.pix = '0;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      sb.push_back(e);
      pixel_en = 1'b1;
      hs = 1'b1;
      vs = 1'b1;
      {red, green, blue} = 8'h00;
      @(negedge clk);
      pixel_en = 1'b0;
    end
    tests++;
    if (locked !== 1'b0 || err_cnt !== err0 + 1) begin
      fails++;
      $display("FAIL stuck_unlock: locked=%0b err pulses=%0d, required 0 1", locked, err_cnt - err0);
    end
    hc = 0;
    vc = 0;
    repeat (3) gen1();
    tests++;
    if (line_len !== 11'd2047) begin
      fails++;
      $display("FAIL stuck_line_len: line_len=%0d, required 2047", line_len);
    end
    run_to(0, 0); gen1();
    run_to(0, 0); gen1(); gen1();
    tests++;
    if (locked !== 1'b1) begin
      fails++;
      $display("FAIL stuck_relock: locked=%0b, required 1", locked);
    end
  endtask

  task automatic test_reset_mid();
    int err0;
    run_to(20, 8);
    err0 = err_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    tests++;
    if ({hcount, vcount, de, pix, locked, line_len, frame_lines, err} !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: hcount=%0d vcount=%0d de=%0b pix=%02h locked=%0b line_len=%0d frame_lines=%0d err=%0b, required all 0",
               hcount, vcount, de, pix, locked, line_len, frame_lines, err);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_locked = 0;
    vs_seen = 0;
    aligned = 0;
    run_to(0, 0); gen1();
    run_to(0, 0); gen1();
    run_to(0, 0); gen1();
    tests++;
    if (locked !== 1'b0) begin
      fails++;
      $display("FAIL reset_relock_early: locked=%0b, required 0", locked);
    end
    gen1();
    tests++;
    if (locked !== 1'b1 || err_cnt !== err0) begin
      fails++;
      $display("FAIL reset_relock: locked=%0b err pulses=%0d, required 1 0", locked, err_cnt - err0);
    end
    repeat (4) gen1();
  endtask

  initial begin
    rst_n = 1'b0;
    pixel_en = 1'b0;
    hs = 1'b1;
    vs = 1'b1;
    {red, green, blue} = 8'h00;
    test_reset();
    test_lock();
    test_ball();
    test_same_edge();
    test_short_line();
    test_stuck_hs();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
Receive-side counterpart of the VGA timing generator. Samples the hs/vs/RGB stream produced by the pong top level and recovers the pixel coordinates and the data-enable signal. Measures line and frame lengths, and asserts lock once the timing matches the expected mode. Used as an on-chip monitor and as the scoreboard front-end in system benches.

Parameters:
H_TOTAL, 800, pixels per line (sync leading edge to next sync leading edge)
H_START, 144, pixels from hs leading edge to first active pixel (sync + back porch)
H_ACTIVE, 640, active pixels per line
V_TOTAL, 525, lines per frame
V_START, 35, lines from vs leading edge to first active line
V_ACTIVE, 480, active lines per frame
HS_POL, 0, asserted level of hs (0 = active-low)
VS_POL, 0, asserted level of vs
LOCK_FRAMES, 2, consecutive good frames required for lock

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pixel_en  in  1  pixel-rate clock enable (clk/2 in current top level); all logic advances only when high
hs  in  1  horizontal sync
vs  in  1  vertical sync
red  in  3  pixel red
green  in  3  pixel green
blue  in  2  pixel blue
hcount  out  11  active-area x (0..H_ACTIVE-1); 0 outside active area
vcount  out  11  active-area y (0..V_ACTIVE-1); 0 outside active area
de  out  1  data enable: active pixel AND locked
pix  out  8  {red,green,blue} registered, aligned with de
locked  out  1  timing lock status
line_len  out  11  last measured line length, saturating at 2047
frame_lines  out  11  last measured line count per frame, saturating at 2047
err  out  1  one-clk pulse on a timing mismatch while locked

Behaviour:
- Reset (async, rst_n low): every output 0; FSM goes to SEARCH; all counters 0; hs_q/vs_q load the deasserted level.
- Sampling: on each clk with pixel_en=1, register hs, vs and RGB (stage 1). Leading edge = stage-1 value goes to the asserted level while the previous value was deasserted.
- hpos: resets to 0 on the hs leading edge, otherwise increments, saturating at 2047. On the hs edge, line_len <= hpos+1 (saturating).
- vpos: resets to 0 on a vs leading edge, and increments on each hs leading edge otherwise. On the vs edge, frame_lines <= vpos+1 (saturating).
- Same-cycle hs and vs edges: hpos and vpos both reset; vpos does not increment.
- Active region: H_START <= hpos < H_START+H_ACTIVE and V_START <= vpos < V_START+V_ACTIVE. In this region hcount = hpos-H_START and vcount = vpos-V_START.
- Output stage (stage 2): hcount, vcount, de and pix update together, 2 pixel_en ticks after the hs/vs/RGB sample. All outputs hold when pixel_en=0.
- Line good: measured length == H_TOTAL. Frame good: frame_lines == V_TOTAL and every line in that frame was good.
- FSM states:
  - SEARCH: wait for the first vs leading edge, then go to VERIFY with good_cnt=0. The first partial frame is never judged.
  - VERIFY: at each vs edge, a good frame increments good_cnt and a bad frame clears it. When good_cnt reaches LOCK_FRAMES, go to LOCKED and set locked=1.
  - LOCKED: the first bad line (at its hs edge) or bad frame (at its vs edge) pulses err for one clk, clears locked and returns to SEARCH. de drops to 0 on the same output-stage update.
- Loss of sync: if hpos saturates (no hs), treat it as a bad line. In LOCKED this pulses err and returns to SEARCH; otherwise it stays in or returns to SEARCH.
- de is never 1 unless locked=1. hcount and vcount still track when unlocked.
- Reset mid-frame: immediate return to reset state, no err pulse.

Decomposition:
- Shared package/defines (defs.v): default 640x480 timing constants (H_TOTAL, H_START, H_ACTIVE, V_TOTAL, V_START, V_ACTIVE, sync polarities). These are the same constants the timing generator uses, so both ends of the link share a single source.
- One sub-module, sync_edge_meas: edge detector plus saturating position counter, instantiated twice (hs/hpos, vs/vpos).
- The FSM and output stage stay in the top.

Test Plan:
- Nominal 640x480 stream from a timing-generator model, pixel_en every 2nd clk:
  - locked=1 at the vs edge ending the 2nd complete frame after the first vs edge.
  - line_len=800, frame_lines=525, err never pulses.
- Locked; ball pixel drawn at x=100, y=50 with RGB=8'hFF: pix=8'hFF with hcount=100, vcount=50, de=1, exactly 2 pixel_en ticks after the RGB sample.
- Locked; one line shortened to 799 pixels: err pulses once at that hs edge, locked=0 and de=0. Relock after 2 further good frames.
- hs held deasserted for 2100 pixels: hpos saturates, line_len=2047, locked=0, de stays 0.
- rst_n low for 3 clks mid-frame while locked: all outputs 0 immediately, no err pulse. Relock takes 2 good frames after the next vs edge.
- hs and vs leading edges in the same sample: vpos=0 and hpos=0 on the next tick; frame_lines updates once, with no extra line counted.
